// File: rtl/panda_lsu_ctrl_if.sv
// Core-side and memory-side signal bundle of the panda load/store sequencer.
// master is the sequencer's view; slave is the view of the core/memory environment.
interface panda_lsu_ctrl_if #(
  parameter int AddrWidth = 32
);
  logic                 lsu_req_i;
  logic                 lsu_we_i;
  logic [1:0]           lsu_width_i;
  logic                 lsu_unsigned_i;
  logic [AddrWidth-1:0] lsu_addr_i;
  logic [31:0]          lsu_wdata_i;
  logic                 lsu_busy_o;
  logic                 lsu_valid_o;
  logic [31:0]          lsu_rdata_o;
  logic                 lsu_err_o;
  logic                 data_req_o;
  logic                 data_gnt_i;
  logic                 data_we_o;
  logic [3:0]           data_be_o;
  logic [AddrWidth-1:0] data_addr_o;
  logic [31:0]          data_wdata_o;
  logic                 data_rvalid_i;
  logic [31:0]          data_rdata_i;

  modport master (
    input  lsu_req_i, lsu_we_i, lsu_width_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
    input  data_gnt_i, data_rvalid_i, data_rdata_i,
    output lsu_busy_o, lsu_valid_o, lsu_rdata_o, lsu_err_o,
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o
  );

  modport slave (
    output lsu_req_i, lsu_we_i, lsu_width_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
    output data_gnt_i, data_rvalid_i, data_rdata_i,
    input  lsu_busy_o, lsu_valid_o, lsu_rdata_o, lsu_err_o,
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o
  );
endinterface

// File: rtl/panda_lsu_ctrl.sv
// Load/store sequencer: splits misaligned accesses into two aligned word transactions.
// Define PANDA_LSU_ALIGN_CHECK_EN to reject split-class accesses with lsu_err_o instead.
module panda_lsu_ctrl #(
  parameter int AddrWidth = 32
) (
  input logic              clk_i,
  input logic              rst_ni,
  panda_lsu_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [1:0]           width_q, width_d;
  logic                 unsigned_q, unsigned_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata0_q, rdata0_d;
  logic [31:0]          rdata_q, rdata_d;
`ifdef PANDA_LSU_ALIGN_CHECK_EN
  logic                 err_q, err_d;
  logic [7:0]           req_be;
`endif

  logic [1:0]           off;
  logic [4:0]           sh;
  logic [7:0]           be_wide;
  logic                 split;
  logic [63:0]          wdata_wide;
  logic [AddrWidth-1:0] word_addr;
  logic [31:0]          rd_lo, rd_hi, raw, load_result;

  function automatic logic [3:0] mask_of(input logic [1:0] w);
    case (w)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    off        = addr_q[1:0];
    sh         = {off, 3'b000};
    be_wide    = {4'b0000, mask_of(width_q)} << off;
    split      = (be_wide[7:4] != 4'b0000);
    wdata_wide = {32'h0, wdata_q} << sh;
    word_addr  = {addr_q[AddrWidth-1:2], 2'b00};
    // Second word arrives live in WAIT1; a non-split access only has the live word.
    if (state_q == WAIT1) begin
      rd_lo = rdata0_q;
      rd_hi = bus.data_rdata_i;
    end else begin
      rd_lo = bus.data_rdata_i;
      rd_hi = 32'h0;
    end
    raw = (rd_lo >> sh) | (rd_hi << (6'd32 - {1'b0, sh}));
    case (width_q)
      2'b00:   load_result = {{24{~unsigned_q & raw[7]}}, raw[7:0]};
      2'b01:   load_result = {{16{~unsigned_q & raw[15]}}, raw[15:0]};
      default: load_result = raw;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    width_d    = width_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata_d    = rdata_q;
`ifdef PANDA_LSU_ALIGN_CHECK_EN
    err_d      = err_q;
    req_be     = {4'b0000, mask_of(bus.lsu_width_i)} << bus.lsu_addr_i[1:0];
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.lsu_req_i) begin
          we_d       = bus.lsu_we_i;
          width_d    = bus.lsu_width_i;
          unsigned_d = bus.lsu_unsigned_i;
          addr_d     = bus.lsu_addr_i;
          wdata_d    = bus.lsu_wdata_i;
          state_d    = REQ0;
`ifdef PANDA_LSU_ALIGN_CHECK_EN
          err_d      = (req_be[7:4] != 4'b0000);
          if (req_be[7:4] != 4'b0000) state_d = DONE;
`endif
        end
      end
      REQ0: if (bus.data_gnt_i) state_d = WAIT0;
      WAIT0: begin
        if (bus.data_rvalid_i) begin
          rdata0_d = bus.data_rdata_i;
          if (split) begin
            state_d = REQ1;
          end else begin
            state_d = DONE;
            if (!we_q) rdata_d = load_result;
          end
        end
      end
      REQ1: if (bus.data_gnt_i) state_d = WAIT1;
      WAIT1: begin
        if (bus.data_rvalid_i) begin
          state_d = DONE;
          if (!we_q) rdata_d = load_result;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.data_req_o   = 1'b0;
    bus.data_we_o    = 1'b0;
    bus.data_be_o    = 4'b0000;
    bus.data_addr_o  = '0;
    bus.data_wdata_o = 32'h0;
    if (state_q == REQ0) begin
      bus.data_req_o   = 1'b1;
      bus.data_we_o    = we_q;
      bus.data_be_o    = be_wide[3:0];
      bus.data_addr_o  = word_addr;
      bus.data_wdata_o = wdata_wide[31:0];
    end else if (state_q == REQ1) begin
      bus.data_req_o   = 1'b1;
      bus.data_we_o    = we_q;
      bus.data_be_o    = be_wide[7:4];
      bus.data_addr_o  = word_addr + AddrWidth'(4);
      bus.data_wdata_o = wdata_wide[63:32];
    end
    bus.lsu_busy_o  = (state_q != IDLE);
    bus.lsu_valid_o = (state_q == DONE);
    bus.lsu_rdata_o = rdata_q;
`ifdef PANDA_LSU_ALIGN_CHECK_EN
    bus.lsu_err_o   = (state_q == DONE) & err_q;
`else
    bus.lsu_err_o   = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      width_q    <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rdata0_q   <= 32'h0;
      rdata_q    <= 32'h0;
`ifdef PANDA_LSU_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      width_q    <= width_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata_q    <= rdata_d;
`ifdef PANDA_LSU_ALIGN_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: doc/panda_lsu_ctrl.md
Name: panda_lsu_ctrl

Overview:
Load/store sequencer between the core datapath and a req/gnt/rvalid data-memory port. It accepts one load or store per request, generates byte enables, and shifts write data. Misaligned halves and words are split into two aligned word transactions, and read data is merged and sign/zero extended. While a transaction is in flight it stalls the core via lsu_busy_o.

Parameters:
AddrWidth, 32, byte address width of core and memory ports.

Ports:
clk_i  in  1  clock; all state on rising edge
rst_ni  in  1  reset, synchronous, active-low
lsu_req_i  in  1  core request; sampled only in IDLE
lsu_we_i  in  1  1 = store, 0 = load
lsu_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
lsu_unsigned_i  in  1  zero-extend load result
lsu_addr_i  in  AddrWidth  byte address
lsu_wdata_i  in  32  store data, LSB-justified
lsu_busy_o  out  1  high whenever state != IDLE
lsu_valid_o  out  1  one-cycle completion pulse
lsu_rdata_o  out  32  extended load result, registered
lsu_err_o  out  1  misalignment error (see Optional Feature)
data_req_o  out  1  memory request
data_gnt_i  in  1  memory grant
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_addr_o  out  AddrWidth  word-aligned address (low 2 bits = 0)
data_wdata_o  out  32  lane-shifted write data
data_rvalid_i  in  1  response / write-completion strobe
data_rdata_i  in  32  read word

Behaviour:
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- Reset (rst_ni low at a clock edge): state goes to IDLE. lsu_valid_o, lsu_busy_o, lsu_err_o, data_req_o, data_we_o = 0. data_be_o = 0, data_addr_o = 0, data_wdata_o = 0, lsu_rdata_o = 0.
- Request capture: in IDLE with lsu_req_i=1, latch we, width, unsigned, addr, wdata and go to REQ0. Requests in any other state are ignored. The core drops lsu_req_i in the lsu_valid_o cycle.
- Access size: mask = 0001/0011/1111 for byte/half/word. off = addr[1:0]. split = (off + size) > 4, i.e. half at off 3, or word at off 1..3. Bytes never split.
- REQ0: data_req_o=1, addr = {addr[31:2],00}, be = (mask<<off)[3:0], wdata = wdata<<(8*off).
  - On gnt: go to WAIT0.
  - All data_* outputs stay stable while req is high and gnt is low.
- WAIT0: data_req_o=0. On rvalid: latch rdata0, then go to REQ1 if split, else DONE.
  - rvalid arrives at the earliest one cycle after gnt; rvalid is ignored outside WAIT states.
- REQ1: addr = word address + 4, modulo 2^AddrWidth (wraps to 0). be = (mask<<off)[7:4], wdata = wdata>>(8*(4-off)). On gnt: go to WAIT1.
- WAIT1: on rvalid, latch rdata1 and go to DONE.
- Load merge: raw = (rdata0>>8*off) | (rdata1<<8*(4-off)) when split, else rdata0>>8*off.
  - Result is raw[7:0] or raw[15:0], sign-extended unless unsigned; words are taken as-is.
  - lsu_rdata_o updates on entry to DONE and holds until the next load completes. Stores do not change it.
- DONE: lsu_valid_o=1 for one cycle, then IDLE.
- Minimum latency, accept edge to lsu_valid_o (gnt immediate, rvalid next cycle): 3 cycles aligned, 5 cycles split.
- Only one memory transaction is ever outstanding.

Optional Feature:
PANDA_LSU_ALIGN_CHECK_EN
- Defined: a split-class access issues no memory transaction. It goes IDLE -> DONE with lsu_valid_o=1 and lsu_err_o=1 for that cycle. lsu_rdata_o is unchanged.
- Undefined: accesses are split as above, and lsu_err_o is tied 0.

Test Plan:
Memory model used below: mem[0x10]=0xAABBCCDD, mem[0x14]=0x11223344.
1. LW 0x10, gnt immediate -> one req: addr 0x10, be F. lsu_rdata_o=0xAABBCCDD, valid 3 cycles after accept.
2. LH 0x12 -> 0xFFFFAABB; LHU 0x12 -> 0x0000AABB; LB 0x11 -> 0xFFFFFFCC; LBU 0x11 -> 0x000000CC. Each uses a single request.
3. LW 0x12 -> reads at 0x10 then 0x14, lsu_rdata_o=0x3344AABB, valid 5 cycles after accept. With the macro defined: no request, lsu_err_o=1.
4. SH 0xBEEF at 0x13 -> write addr 0x10 be 1000 wdata[31:24]=0xEF, then addr 0x14 be 0001 wdata[7:0]=0xBE. SB 0x5A at 0x11 -> be 0010, wdata[15:8]=0x5A.
5. gnt held low 3 cycles in REQ0 -> addr/be/we/wdata stable, lsu_busy_o=1. LW at 0xFFFFFFFE -> second address 0x00000000.
6. rst_ni low for one edge in WAIT0 -> IDLE, data_req_o=0; a late rvalid is ignored, with no lsu_valid_o and lsu_rdata_o=0.
